// File: rtl/inst_prefetch_buffer_if.sv
// Fetch-stage bus. The prefetch buffer uses the master side. The instruction
// memory and the decode consumer use the slave side.
interface inst_prefetch_buffer_if #(
   parameter int DEPTH = 4
) ();
   logic [31:0]             imem_addr;
   logic [7:0]              imem_rdata;
   logic                    redirect;
   logic [31:0]             redirect_pc;
   logic                    inst_ready;
   logic                    inst_valid;
   logic [31:0]             inst_out;
   logic [31:0]             inst_pc;
   logic [$clog2(DEPTH):0]  fifo_count;

   modport master (
      output imem_addr, inst_valid, inst_out, inst_pc, fifo_count,
      input  imem_rdata, redirect, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_addr, inst_valid, inst_out, inst_pc, fifo_count,
      output imem_rdata, redirect, redirect_pc, inst_ready
   );
endinterface

// File: rtl/inst_prefetch_buffer.sv
// Byte-serial instruction fetch. It assembles big-endian words, queues each
// {word, pc} pair in a small FIFO, and flushes and restarts on a redirect.
module inst_prefetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input logic                    clk,
   input logic                    rst,
   inst_prefetch_buffer_if.master bus
);
   localparam int              PW         = $clog2(DEPTH);
   localparam int              CW         = PW + 1;
   localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

   typedef enum logic {FILL, HOLD} state_t;

   state_t        state, state_next;
   logic [31:0]   fetch_pc;
   logic [1:0]    byte_idx;
   logic [31:0]   asm_word, next_word;
   logic [31:0]   inst_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          capture, word_ready, pop, space, push;

   // A pop frees a slot on the same edge, so a full FIFO can still accept a push.
   assign pop   = (count != '0) && bus.inst_ready;
   assign space = (count != FULL_COUNT) || pop;
   assign push  = word_ready && space && !bus.redirect;

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples pre-edge values regardless of block ordering.
      if (rst) state <= FILL;
      else     state <= state_next;
   end

   // FSM next-state logic.
   always_comb begin
      // NOTE: default first, so no path through the block leaves state_next
      // unassigned and no latch is inferred.
      state_next = state;
      if (bus.redirect) begin
         state_next = FILL;
      end else begin
         unique case (state)
            FILL: if (byte_idx == 2'd3 && !space) state_next = HOLD;
            HOLD: if (space)                      state_next = FILL;
         endcase
      end
   end

   // FSM outputs.
   always_comb begin
      capture    = (state == FILL);
      word_ready = (state == HOLD) || (state == FILL && byte_idx == 2'd3);
   end

   // Lane (3 - byte_idx) is the big-endian slot for the current byte.
   always_comb begin
      next_word = asm_word;
      if (capture) next_word[{~byte_idx, 3'b000} +: 8] = bus.imem_rdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         byte_idx <= 2'd0;
         asm_word <= '0;
      end else if (bus.redirect) begin
         fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
         byte_idx <= 2'd0;
         asm_word <= '0;
      end else begin
         asm_word <= next_word;
         if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
            byte_idx <= 2'd0;
         end else if (capture && byte_idx != 2'd3) begin
            byte_idx <= byte_idx + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (bus.redirect) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   // NOTE: the storage array is not reset. Entries are only visible while
   // count covers them, and the head outputs are forced to zero when empty.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem[wr_ptr] <= next_word;
         pc_mem[wr_ptr]   <= fetch_pc;
      end
   end

   assign bus.imem_addr  = fetch_pc + {30'd0, byte_idx};
   assign bus.inst_valid = (count != '0);
   assign bus.inst_out   = (count != '0) ? inst_mem[rd_ptr] : '0;
   assign bus.inst_pc    = (count != '0) ? pc_mem[rd_ptr]   : '0;
   assign bus.fifo_count = count;
endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Scoreboard bench for inst_prefetch_buffer. Each redirect or reset loads the
// expected fetch stream, and a negedge monitor checks every pop against it.
module tb_inst_prefetch_buffer;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } fetch_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   int     checks    = 0;
   int     passed    = 0;
   int     pops_seen = 0;
   int     max_count = 0;
   fetch_t exp_q[$];

   inst_prefetch_buffer_if #(.DEPTH(DEPTH)) bus ();

   inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Instruction memory: four fixed words at 0..15, hashed bytes elsewhere.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      if (a[31:4] == 28'd0) begin
         case (a[3:0])
            4'h0: return 8'h8C;  4'h1: return 8'h01;  4'h2: return 8'h00;  4'h3: return 8'h04;
            4'h4: return 8'h20;  4'h5: return 8'h42;  4'h6: return 8'h00;  4'h7: return 8'h07;
            4'h8: return 8'hAC;  4'h9: return 8'h43;  4'hA: return 8'h00;  4'hB: return 8'h08;
            4'hC: return 8'h10;  4'hD: return 8'h22;  4'hE: return 8'hFF;  default: return 8'hFD;
         endcase
      end
      return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] p);
      return {mem_byte(p), mem_byte(p + 32'd1), mem_byte(p + 32'd2), mem_byte(p + 32'd3)};
   endfunction

   assign bus.imem_rdata = mem_byte(bus.imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Expected stream after a restart: consecutive aligned words, wrapping at 2^32.
   task automatic restart(input logic [31:0] target);
      logic [31:0] p;
      p = {target[31:2], 2'b00};
      exp_q.delete();
      for (int i = 0; i < 256; i++) begin
         exp_q.push_back('{pc: p, word: word_at(p)});
         p = p + 32'd4;
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called just after a posedge. It releases reset before the next edge.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      restart(32'h0);
      rst = 1'b0;
   endtask

   task automatic redirect_to(input logic [31:0] target);
      bus.redirect    = 1'b1;
      bus.redirect_pc = target;
      restart(target);
   endtask

   // Monitor: a pop happens on the next posedge when valid && ready with no redirect or reset.
   always @(negedge clk) begin
      fetch_t e;
      if (!rst && !bus.redirect) begin
         check("count_bound", 32'(bus.fifo_count <= DEPTH), 32'd1);
         if (int'(bus.fifo_count) > max_count) max_count = int'(bus.fifo_count);
         if (!bus.inst_valid) check("empty_head_zero", bus.inst_out | bus.inst_pc, 32'd0);
         if (bus.inst_valid && bus.inst_ready) begin
            pops_seen++;
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL pop_unexpected: got pc %h expected no pop", bus.inst_pc);
            end else begin
               e = exp_q.pop_front();
               check("pop_pc", bus.inst_pc, e.pc);
               check("pop_word", bus.inst_out, e.word);
            end
         end
      end
   end

   initial begin
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.inst_ready  = 1'b0;
      step(2);

      // Reset applied mid-fill, with one word already queued.
      do_reset();
      step(6);
      rst = 1'b1;
      #1;
      check("rst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_count", 32'(bus.fifo_count), 32'd0);
      check("rst_addr", bus.imem_addr, 32'h0);
      restart(32'h0);
      rst = 1'b0;
      step(3);
      check("first_valid_early", 32'(bus.inst_valid), 32'd0);
      step(1);
      check("first_valid", 32'(bus.inst_valid), 32'd1);
      check("first_inst", bus.inst_out, 32'h8C010004);
      check("first_pc", bus.inst_pc, 32'h0);

      // Streaming with a consumer that is always ready.
      step(1);
      do_reset();
      bus.inst_ready = 1'b1;
      max_count = 0;
      pops_seen = 0;
      step(17);
      check("stream_pops", 32'(pops_seen), 32'd4);
      check("stream_max_count", 32'(max_count <= 1), 32'd1);

      // Backpressure: the FIFO fills, then fetch parks in HOLD.
      do_reset();
      bus.inst_ready = 1'b0;
      step(16);
      check("bp_full", 32'(bus.fifo_count), 32'd4);
      check("bp_head_pc", bus.inst_pc, 32'h0);
      step(4);
      check("bp_hold_addr", bus.imem_addr, 32'h13);
      step(2);
      check("bp_hold_addr_stable", bus.imem_addr, 32'h13);
      check("bp_still_full", 32'(bus.fifo_count), 32'd4);
      bus.inst_ready = 1'b1;
      step(1);
      bus.inst_ready = 1'b0;
      check("bp_pushpop_count", 32'(bus.fifo_count), 32'd4);
      check("bp_pushpop_pc", bus.inst_pc, 32'h4);
      check("bp_resume_addr", bus.imem_addr, 32'h14);
      bus.inst_ready = 1'b1;
      step(6);

      // Redirect flush with a pop on the same edge.
      do_reset();
      bus.inst_ready = 1'b0;
      step(12);
      check("rd_pre_count", 32'(bus.fifo_count), 32'd3);
      redirect_to(32'h00000016);
      bus.inst_ready = 1'b1;
      step(1);
      bus.redirect   = 1'b0;
      bus.inst_ready = 1'b0;
      check("rd_count", 32'(bus.fifo_count), 32'd0);
      check("rd_valid", 32'(bus.inst_valid), 32'd0);
      check("rd_addr", bus.imem_addr, 32'h14);
      step(4);
      check("rd_first_valid", 32'(bus.inst_valid), 32'd1);
      check("rd_first_pc", bus.inst_pc, 32'h14);
      check("rd_first_inst", bus.inst_out, word_at(32'h14));
      bus.inst_ready = 1'b1;
      step(8);

      // Address wrap at the top of the address space.
      bus.inst_ready = 1'b0;
      redirect_to(32'hFFFFFFFC);
      step(1);
      bus.redirect = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("wrap_addr", bus.imem_addr, 32'hFFFFFFFC + 32'(i));
         step(1);
      end
      check("wrap_pc", bus.inst_pc, 32'hFFFFFFFC);
      check("wrap_inst", bus.inst_out, word_at(32'hFFFFFFFC));
      check("wrap_next_addr", bus.imem_addr, 32'h0);
      bus.inst_ready = 1'b1;
      step(12);

      // Random phase: ready stalls, occasional redirects (sometimes held high).
      pops_seen = 0;
      for (int i = 0; i < 800; i++) begin
         if (($urandom_range(0, 99) < 3) || (bus.redirect && $urandom_range(0, 1) == 1))
            redirect_to($urandom);
         else
            bus.redirect = 1'b0;
         bus.inst_ready = ($urandom_range(0, 2) != 0);
         step(1);
      end
      bus.redirect   = 1'b0;
      bus.inst_ready = 1'b1;
      step(10);
      check("random_pops", 32'(pops_seen >= 20), 32'd1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
